// File: rtl/fetch_queue_pkg.sv
// rtl/fetch_queue_pkg.sv - shared address-map constants for the fetch queue
// Holds the pc reset value, the instruction-memory window and the nop encoding.
package fetch_queue_pkg;

  localparam logic [31:0] PC_RESET = 32'h0000_3000;
  localparam logic [31:0] IM_BASE  = 32'h0000_3000;
  localparam logic [31:0] IM_TOP   = 32'h0000_6FFC;
  localparam logic [31:0] NOP      = 32'h0000_0000;

endpackage

// File: rtl/fq_exc_check.sv
// rtl/fq_exc_check.sv - combinational fetch-fault check (pc -> exc)
// Flags misaligned pcs and pcs outside the instruction-memory window.
module fq_exc_check
  import fetch_queue_pkg::*;
#(
  parameter int PC_W = 32
) (
  input  logic [PC_W-1:0] i_pc,
  output logic            o_exc
);

  localparam logic [PC_W-1:0] L_BASE = PC_W'(IM_BASE);
  localparam logic [PC_W-1:0] L_TOP  = PC_W'(IM_TOP);

  assign o_exc = (i_pc[1:0] != 2'b00) | (i_pc < L_BASE) | (i_pc > L_TOP);

endmodule

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - in-order {pc, instr} buffer between fetch and decode
// Optional per-entry fetch-fault bit enabled by defining FQ_EXC_EN.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int PC_W    = 32,
  parameter int INSTR_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  input  logic [PC_W-1:0]    in_pc,
  input  logic [INSTR_W-1:0] in_instr,
  output logic               full,
  input  logic               flush,
  output logic               out_valid,
  output logic [PC_W-1:0]    out_pc,
  output logic [INSTR_W-1:0] out_instr,
  input  logic               out_ready,
  output logic               out_exc
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0]      r_wr_ptr;
  logic [AW-1:0]      r_rd_ptr;
  logic [CW-1:0]      r_count;
  logic [PC_W-1:0]    r_pc_mem    [DEPTH];
  logic [INSTR_W-1:0] r_instr_mem [DEPTH];

  logic               w_push;
  logic               w_pop;
  logic [INSTR_W-1:0] w_instr_wr;

  assign full      = (r_count == CW'(DEPTH));
  assign out_valid = (r_count != '0);
  assign w_push    = in_valid & ~full & ~flush;
  assign w_pop     = out_valid & out_ready & ~flush;

`ifdef FQ_EXC_EN
  logic         w_exc;
  logic [DEPTH-1:0] r_exc_mem;

  fq_exc_check #(.PC_W(PC_W)) u_exc_check (
    .i_pc  (in_pc),
    .o_exc (w_exc)
  );

  // A faulting fetch is carried down the pipe as a nop so decode never acts on it.
  assign w_instr_wr = w_exc ? INSTR_W'(NOP) : in_instr;
  assign out_exc    = out_valid & r_exc_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_exc_mem[r_wr_ptr] <= w_exc;
    end
  end
`else
  assign w_instr_wr = in_instr;
  assign out_exc    = 1'b0;
`endif

  assign out_pc    = out_valid ? r_pc_mem[r_rd_ptr]    : '0;
  assign out_instr = out_valid ? r_instr_mem[r_rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_pc_mem[r_wr_ptr]    <= in_pc;
      r_instr_mem[r_wr_ptr] <= w_instr_wr;
    end
  end

  // Reset and flush both discard every entry; push/pop are already gated by flush.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - self-checking bench for fetch_queue (honours FQ_EXC_EN)
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_pc = '0;
  logic [31:0] in_instr = '0;
  logic        full;
  logic        flush = 1'b0;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        out_ready = 1'b0;
  logic        out_exc;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  fetch_queue dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_pc     (in_pc),
    .in_instr  (in_instr),
    .full      (full),
    .flush     (flush),
    .out_valid (out_valid),
    .out_pc    (out_pc),
    .out_instr (out_instr),
    .out_ready (out_ready),
    .out_exc   (out_exc)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        exc;
  } ent_t;

  ent_t mq[$];

  typedef struct {
    logic        rst;
    logic        vld;
    logic [31:0] pc;
    logic        fl;
    logic        rdy;
    logic        e_valid;
    logic        e_full;
    logic [31:0] e_pc;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic rst, logic vld, logic [31:0] pc, logic fl, logic rdy,
                              logic ev, logic ef, logic [31:0] epc);
    vec_t v;
    v.rst = rst; v.vld = vld; v.pc = pc; v.fl = fl; v.rdy = rdy;
    v.e_valid = ev; v.e_full = ef; v.e_pc = epc;
    return v;
  endfunction

  function automatic logic [31:0] instr_of(logic [31:0] pc);
    return ~pc ^ 32'h5A5A_0000;
  endfunction

  function automatic logic exc_of(logic [31:0] pc);
`ifdef FQ_EXC_EN
    return (pc[1:0] != 2'b00) || (pc < 32'h0000_3000) || (pc > 32'h0000_6FFC);
`else
    return 1'b0;
`endif
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Queue-level reference: refuse push when full (before any pop), drop all on reset/flush.
  task automatic model_step(logic rst, logic vld, logic [31:0] pc, logic [31:0] ins,
                            logic fl, logic rdy);
    ent_t e;
    bit do_pop;
    bit do_push;
    if (rst || fl) begin
      mq.delete();
    end else begin
      do_pop  = (mq.size() != 0) && rdy;
      do_push = vld && (mq.size() < 4);
      if (do_pop) void'(mq.pop_front());
      if (do_push) begin
        e.exc   = exc_of(pc);
        e.pc    = pc;
        e.instr = e.exc ? 32'h0 : ins;
        mq.push_back(e);
      end
    end
  endtask

  task automatic cycle(logic rst, logic vld, logic [31:0] pc, logic [31:0] ins,
                       logic fl, logic rdy);
    reset = rst; in_valid = vld; in_pc = pc; in_instr = ins; flush = fl; out_ready = rdy;
    @(posedge clk);
    model_step(rst, vld, pc, ins, fl, rdy);
    #1;
  endtask

  task automatic check_model(string tag);
    logic        ev, ef, ee;
    logic [31:0] ep, ei;
    ev = (mq.size() != 0);
    ef = (mq.size() == 4);
    ep = ev ? mq[0].pc : 32'h0;
    ei = ev ? mq[0].instr : 32'h0;
    ee = ev ? mq[0].exc : 1'b0;
    check({tag, " out_valid"}, {31'b0, out_valid}, {31'b0, ev});
    check({tag, " full"},      {31'b0, full},      {31'b0, ef});
    check({tag, " out_pc"},    out_pc,             ep);
    check({tag, " out_instr"}, out_instr,          ei);
    check({tag, " out_exc"},   {31'b0, out_exc},   {31'b0, ee});
  endtask

  initial begin
    vec_t v;
    logic [31:0] rpc;
    logic        rv, rr, rf, rs;

    // reset, fill to full, refused push while full, flush at count 3, stream, reset mid-run
    vecs.push_back(mk(1, 0, 32'h0,    0, 0, 0, 0, 32'h0));
    vecs.push_back(mk(0, 1, 32'h3000, 0, 0, 1, 0, 32'h3000));
    vecs.push_back(mk(0, 1, 32'h3004, 0, 0, 1, 0, 32'h3000));
    vecs.push_back(mk(0, 1, 32'h3008, 0, 0, 1, 0, 32'h3000));
    vecs.push_back(mk(0, 1, 32'h300C, 0, 0, 1, 1, 32'h3000));
    vecs.push_back(mk(0, 1, 32'h3010, 0, 1, 1, 0, 32'h3004));
    vecs.push_back(mk(0, 0, 32'h0,    0, 0, 1, 0, 32'h3004));
    vecs.push_back(mk(0, 1, 32'h3010, 1, 1, 0, 0, 32'h0));
    vecs.push_back(mk(0, 1, 32'h3020, 0, 1, 1, 0, 32'h3020));
    vecs.push_back(mk(0, 0, 32'h0,    0, 1, 0, 0, 32'h0));
    vecs.push_back(mk(0, 1, 32'h3000, 0, 1, 1, 0, 32'h3000));
    vecs.push_back(mk(0, 1, 32'h3004, 0, 1, 1, 0, 32'h3004));
    vecs.push_back(mk(0, 1, 32'h3008, 0, 1, 1, 0, 32'h3008));
    vecs.push_back(mk(0, 0, 32'h0,    0, 1, 0, 0, 32'h0));
    vecs.push_back(mk(0, 1, 32'h3100, 0, 0, 1, 0, 32'h3100));
    vecs.push_back(mk(1, 1, 32'h3104, 0, 1, 0, 0, 32'h0));

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      cycle(v.rst, v.vld, v.pc, instr_of(v.pc), v.fl, v.rdy);
      check($sformatf("vec%0d out_valid", i), {31'b0, out_valid}, {31'b0, v.e_valid});
      check($sformatf("vec%0d full", i),      {31'b0, full},      {31'b0, v.e_full});
      check($sformatf("vec%0d out_pc", i),    out_pc,             v.e_pc);
      check($sformatf("vec%0d out_instr", i), out_instr,          v.e_valid ? instr_of(v.e_pc) : 32'h0);
      check($sformatf("vec%0d out_exc", i),   {31'b0, out_exc},   32'h0);
    end

    // fetch-fault entries: misaligned pc and pc beyond the memory window, then a good pc
    cycle(0, 1, 32'h3002, instr_of(32'h3002), 0, 0);
    cycle(0, 1, 32'h7000, instr_of(32'h7000), 0, 0);
    cycle(0, 1, 32'h3004, instr_of(32'h3004), 0, 0);
    cycle(0, 0, 32'h0, 32'h0, 0, 0);
`ifdef FQ_EXC_EN
    check("exc 3002 out_exc",   {31'b0, out_exc}, 32'h1);
    check("exc 3002 out_instr", out_instr,        32'h0);
`else
    check("exc 3002 out_exc",   {31'b0, out_exc}, 32'h0);
    check("exc 3002 out_instr", out_instr,        instr_of(32'h3002));
`endif
    check("exc 3002 out_pc", out_pc, 32'h3002);
    cycle(0, 0, 32'h0, 32'h0, 0, 1);
`ifdef FQ_EXC_EN
    check("exc 7000 out_exc",   {31'b0, out_exc}, 32'h1);
    check("exc 7000 out_instr", out_instr,        32'h0);
`else
    check("exc 7000 out_exc",   {31'b0, out_exc}, 32'h0);
    check("exc 7000 out_instr", out_instr,        instr_of(32'h7000));
`endif
    check("exc 7000 out_pc", out_pc, 32'h7000);
    cycle(0, 0, 32'h0, 32'h0, 0, 1);
    check("exc 3004 out_exc",   {31'b0, out_exc}, 32'h0);
    check("exc 3004 out_instr", out_instr,        instr_of(32'h3004));
    cycle(0, 0, 32'h0, 32'h0, 0, 1);
    check_model("exc drained");

    // randomized traffic with wraparound, random backpressure, flushes and resets
    for (int n = 0; n < 500; n++) begin
      if ($urandom_range(0, 9) == 0) rpc = $urandom();
      else rpc = 32'h3000 + 32'($urandom_range(0, 4095)) * 4;
      rs = ($urandom_range(0, 99) == 0);
      rf = ($urandom_range(0, 24) == 0);
      rv = ($urandom_range(0, 3) != 0);
      rr = ($urandom_range(0, 1) == 1);
      cycle(rs, rv, rpc, $urandom(), rf, rr);
      check_model($sformatf("rnd%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
